// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
//
// Read-side frame fetcher running in the SDRAM clock domain. Each VGA frame
// start (vsync, resynchronized here) clears the display FIFO and streams one
// complete frame out of the currently displayed SDRAM bank into that FIFO. It
// does this with a series of burst read requests, issued only while the FIFO
// has enough free room. When the whole frame has been fetched, vga_rise is
// held high for RISE_HOLD cycles so the bank switcher can advance the display
// to the newest complete bank.
//
// Ports
//   clk           SDRAM-domain clock
//   rst_133       asynchronous active-low reset
//   vga_vsync     frame-start level from the VGA domain (asynchronous)
//   vga_bank      bank to display; latched only at frame start
//   fifo_wrusedw  used words at the FIFO write side
//   fifo_aclr     one-cycle FIFO clear at frame start
//   sd_rd_req     burst read request, held until sd_rd_ack
//   sd_rd_ack     controller accepted the request (1-cycle pulse)
//   sd_rd_done    last word of the burst is in the FIFO (1-cycle pulse)
//   sd_rd_bank    bank of the current burst
//   sd_rd_addr    start word address of the current burst
//   sd_rd_len     burst length in words
//   vga_rise      frame-complete indication, RISE_HOLD cycles wide
//   frame_late    one-cycle pulse: vsync arrived before the fetch completed
// -----------------------------------------------------------------------------
module vga_frame_reader #(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 256,
  parameter int ADDR_W      = 19,
  parameter int FIFO_AW     = 10,
  parameter int FIFO_ROOM   = 512,
  parameter int RISE_HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic              vga_vsync,
  input  logic [1:0]        vga_bank,
  input  logic [FIFO_AW:0]  fifo_wrusedw,
  output logic              fifo_aclr,
  output logic              sd_rd_req,
  input  logic              sd_rd_ack,
  input  logic              sd_rd_done,
  output logic [1:0]        sd_rd_bank,
  output logic [ADDR_W-1:0] sd_rd_addr,
  output logic [9:0]        sd_rd_len,
  output logic              vga_rise,
  output logic              frame_late
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  // One extra bit on the counter arithmetic so FRAME_WORDS itself fits.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_LEN);

  // Free-space arithmetic: 2^FIFO_AW needs FIFO_AW+1 bits, plus headroom.
  localparam int FW = FIFO_AW + 2;
  localparam logic [FW-1:0] FIFO_DEPTH_C = FW'(2 ** FIFO_AW);
  localparam logic [FW-1:0] ROOM_C       = FW'(FIFO_ROOM);

  localparam int HW = $clog2(RISE_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RISE_HOLD - 1);

  // ---------------------------------------------------------------------------
  // vsync synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic vs_meta_q, vs_sync_q, vs_dly_q;
  logic fs;

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_dly_q  <= 1'b0;
    end else begin
      vs_meta_q <= vga_vsync;
      vs_sync_q <= vs_meta_q;
      vs_dly_q  <= vs_sync_q;
    end
  end

  assign fs = vs_sync_q & ~vs_dly_q;

  // ---------------------------------------------------------------------------
  // Frame fetch FSM
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          bk_lat_q, bk_lat_d;
  logic                pend_q, pend_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [9:0]          len_q, len_d;
  logic                req_q, rise_q, aclr_q, late_q;
  logic                aclr_d, late_d;
  logic                start;

  logic [CW-1:0]       rem;
  logic [CW-1:0]       cnt_sum;
  logic [FW-1:0]       free;

  assign rem     = FRAME_C - {1'b0, cnt_q};
  assign cnt_sum = {1'b0, cnt_q} + CW'(len_q);
  assign free    = FIFO_DEPTH_C - {1'b0, fifo_wrusedw};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bk_lat_d = bk_lat_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    addr_d   = addr_q;
    len_d    = len_q;
    aclr_d   = 1'b0;
    late_d   = 1'b0;
    start    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fs) start = 1'b1;
      end

      S_CHECK: begin
        if (fs) begin
          // Nothing outstanding at the controller: restart on the spot.
          late_d = 1'b1;
          start  = 1'b1;
        end else if (free >= ROOM_C) begin
          state_d = S_REQ;
          addr_d  = cnt_q;
          len_d   = (rem < BURST_C) ? 10'(rem) : 10'(BURST_LEN);
        end
      end

      S_REQ: begin
        // The handshake must complete; a new frame waits for its done.
        if (fs) begin
          late_d = 1'b1;
          pend_d = 1'b1;
        end
        if (sd_rd_ack) state_d = S_WAIT;
      end

      S_WAIT: begin
        if (fs) late_d = 1'b1;
        if (sd_rd_done) begin
          if (pend_q || fs) begin
            start = 1'b1;
          end else begin
            cnt_d   = cnt_sum[ADDR_W-1:0];
            hold_d  = '0;
            state_d = (cnt_sum == FRAME_C) ? S_DONE : S_CHECK;
          end
        end else if (fs) begin
          pend_d = 1'b1;
        end
      end

      S_DONE: begin
        // A vsync here is on time; it is remembered and served once the
        // rise pulse has run its full length.
        if (fs) pend_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          if (pend_q || fs) start = 1'b1;
          else              state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start) begin
      bk_lat_d = vga_bank;
      cnt_d    = '0;
      pend_d   = 1'b0;
      aclr_d   = 1'b1;
      state_d  = S_CHECK;
    end
  end

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bk_lat_q <= 2'b00;
      pend_q   <= 1'b0;
      hold_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      req_q    <= 1'b0;
      rise_q   <= 1'b0;
      aclr_q   <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bk_lat_q <= bk_lat_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      // Outputs registered from the next state so they are glitch-free and
      // line up exactly with the state they describe.
      req_q    <= (state_d == S_REQ);
      rise_q   <= (state_d == S_DONE);
      aclr_q   <= aclr_d;
      late_q   <= late_d;
    end
  end

  assign fifo_aclr  = aclr_q;
  assign sd_rd_req  = req_q;
  assign sd_rd_bank = bk_lat_q;
  assign sd_rd_addr = addr_q;
  assign sd_rd_len  = len_q;
  assign vga_rise   = rise_q;
  assign frame_late = late_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

  localparam int FW_P = 20;
  localparam int BL_P = 8;
  localparam int AW_P = 19;
  localparam int FA_P = 5;
  localparam int FR_P = 8;
  localparam int RH_P = 4;
  localparam int NB_P = (FW_P + BL_P - 1) / BL_P;

  logic            clk = 1'b0;
  logic            rst_133 = 1'b0;
  logic            vga_vsync = 1'b0;
  logic [1:0]      vga_bank = 2'b00;
  logic [FA_P:0]   fifo_wrusedw = '0;
  logic            fifo_aclr;
  logic            sd_rd_req;
  logic            sd_rd_ack = 1'b0;
  logic            sd_rd_done = 1'b0;
  logic [1:0]      sd_rd_bank;
  logic [AW_P-1:0] sd_rd_addr;
  logic [9:0]      sd_rd_len;
  logic            vga_rise;
  logic            frame_late;

  vga_frame_reader #(
    .FRAME_WORDS(FW_P), .BURST_LEN(BL_P), .ADDR_W(AW_P),
    .FIFO_AW(FA_P), .FIFO_ROOM(FR_P), .RISE_HOLD(RH_P)
  ) dut (
    .clk(clk), .rst_133(rst_133), .vga_vsync(vga_vsync), .vga_bank(vga_bank),
    .fifo_wrusedw(fifo_wrusedw), .fifo_aclr(fifo_aclr), .sd_rd_req(sd_rd_req),
    .sd_rd_ack(sd_rd_ack), .sd_rd_done(sd_rd_done), .sd_rd_bank(sd_rd_bank),
    .sd_rd_addr(sd_rd_addr), .sd_rd_len(sd_rd_len), .vga_rise(vga_rise),
    .frame_late(frame_late)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Event counters observed on the falling edge.
  int   req_rise_cnt = 0;
  int   aclr_cnt = 0;
  int   late_cnt = 0;
  int   rise_cnt = 0;
  logic req_prev = 1'b0;

  always @(negedge clk) begin
    if (sd_rd_req && !req_prev) req_rise_cnt++;
    req_prev = sd_rd_req;
    if (fifo_aclr)  aclr_cnt++;
    if (frame_late) late_cnt++;
    if (vga_rise)   rise_cnt++;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is cut into bursts of BURST_LEN words, the last
  // one carrying whatever remains.
  function automatic int model_addr(input int k);
    return k * BL_P;
  endfunction

  function automatic int model_len(input int k);
    int r;
    r = FW_P - k * BL_P;
    return (r < BL_P) ? r : BL_P;
  endfunction

  task automatic pulse_vsync();
    vga_vsync = 1'b1;
    repeat (3) @(negedge clk);
    vga_vsync = 1'b0;
  endtask

  // Wait for a request, check its fields, optionally hold off the ack for
  // ack_dly cycles (fields must stay put) and then acknowledge it.
  task automatic req_phase(input int ea, input int el, input logic [1:0] eb,
                           input int ack_dly, input bit do_ack);
    int n;
    n = 0;
    while (sd_rd_req !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", sd_rd_req, 1);
    check_eq("req_addr", sd_rd_addr, ea);
    check_eq("req_len", sd_rd_len, el);
    check_eq("req_bank", sd_rd_bank, eb);
    $display("burst addr=%0d len=%0d bank=%0d ack_dly=%0d", sd_rd_addr, sd_rd_len, sd_rd_bank, ack_dly);
    if (do_ack) begin
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        check_eq("hold_req", sd_rd_req, 1);
        check_eq("hold_addr", sd_rd_addr, ea);
        check_eq("hold_len", sd_rd_len, el);
        check_eq("hold_bank", sd_rd_bank, eb);
      end
      sd_rd_ack = 1'b1;
      @(negedge clk);
      sd_rd_ack = 1'b0;
      check_eq("req_drop", sd_rd_req, 0);
    end
  endtask

  task automatic done_phase(input int dd);
    repeat (dd) @(negedge clk);
    sd_rd_done = 1'b1;
    @(negedge clk);
    sd_rd_done = 1'b0;
  endtask

  task automatic serve_bursts(input int k_from, input int k_to, input logic [1:0] bk,
                              input int ack, input int dn);
    for (int k = k_from; k <= k_to; k++) begin
      req_phase(model_addr(k), model_len(k), bk, ack, 1'b1);
      done_phase(dn);
      check_eq("rise_after_done", vga_rise, (k == NB_P - 1) ? 1 : 0);
    end
  endtask

  task automatic end_check(input int a0, input int r0, input int l0, input int h0,
                           input int ea, input int er, input int el, input int eh);
    repeat (12) @(negedge clk);
    check_eq("aclr_pulses", aclr_cnt - a0, ea);
    check_eq("req_count", req_rise_cnt - r0, er);
    check_eq("late_pulses", late_cnt - l0, el);
    check_eq("rise_cycles", rise_cnt - h0, eh);
    check_eq("idle_req", sd_rd_req, 0);
  endtask

  task automatic run_frame(input logic [1:0] bk, input bit chg, input logic [1:0] nb,
                           input int ack, input int dn, input int used);
    int a0, r0, l0, h0;
    a0 = aclr_cnt; r0 = req_rise_cnt; l0 = late_cnt; h0 = rise_cnt;
    fifo_wrusedw = (FA_P + 1)'(used);
    vga_bank = bk;
    pulse_vsync();
    serve_bursts(0, 0, bk, ack, dn);
    if (chg) vga_bank = nb;
    serve_bursts(1, NB_P - 1, bk, ack, dn);
    end_check(a0, r0, l0, h0, 1, NB_P, 0, RH_P);
    $display("frame bank=%0d done", bk);
  endtask

  initial begin
    int a0, r0, l0, h0, n, bp_req;
    logic [1:0] bk, nb;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_aclr", fifo_aclr, 0);
    check_eq("rst_req", sd_rd_req, 0);
    check_eq("rst_rise", vga_rise, 0);
    check_eq("rst_late", frame_late, 0);
    check_eq("rst_addr", sd_rd_addr, 0);
    check_eq("rst_len", sd_rd_len, 0);
    check_eq("rst_bank", sd_rd_bank, 0);
    rst_133 = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    run_frame(2'b01, 1'b0, 2'b00, 1, 5, 0);

    // Request hold with a slow ack
    run_frame(2'b11, 1'b0, 2'b00, 10, 2, 0);

    // Bank change mid-frame, then the next frame picks it up
    run_frame(2'b01, 1'b1, 2'b10, 1, 3, 0);
    run_frame(2'b10, 1'b0, 2'b00, 0, 0, 0);

    // FIFO backpressure
    a0 = aclr_cnt; r0 = req_rise_cnt; l0 = late_cnt; h0 = rise_cnt;
    fifo_wrusedw = 6'd30;
    vga_bank = 2'b01;
    pulse_vsync();
    bp_req = 0;
    repeat (50) begin
      @(negedge clk);
      if (sd_rd_req) bp_req++;
    end
    check_eq("bp_no_req", bp_req, 0);
    fifo_wrusedw = 6'd20;
    n = 0;
    while (sd_rd_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_release_latency_ok", (n >= 1 && n <= 2) ? 1 : 0, 1);
    serve_bursts(0, NB_P - 1, 2'b01, 1, 2);
    end_check(a0, r0, l0, h0, 1, NB_P, 0, RH_P);
    fifo_wrusedw = '0;

    // Late vsync while waiting for the done of burst 2
    a0 = aclr_cnt; r0 = req_rise_cnt; l0 = late_cnt; h0 = rise_cnt;
    bk = 2'b10; nb = 2'b11;
    vga_bank = bk;
    pulse_vsync();
    serve_bursts(0, 0, bk, 1, 2);
    req_phase(model_addr(1), model_len(1), bk, 1, 1'b1);
    vga_bank = nb;
    pulse_vsync();
    repeat (4) @(negedge clk);
    check_eq("late_pulse", late_cnt - l0, 1);
    check_eq("late_no_restart_yet", aclr_cnt - a0, 1);
    check_eq("late_wait_req", sd_rd_req, 0);
    done_phase(0);
    check_eq("late_no_rise", vga_rise, 0);
    serve_bursts(0, NB_P - 1, nb, 1, 2);
    end_check(a0, r0, l0, h0, 2, 2 + NB_P, 1, RH_P);

    // vsync landing during the rise pulse: served after it, not late
    a0 = aclr_cnt; r0 = req_rise_cnt; l0 = late_cnt; h0 = rise_cnt;
    bk = 2'b00; nb = 2'b01;
    vga_bank = bk;
    pulse_vsync();
    serve_bursts(0, NB_P - 2, bk, 0, 1);
    req_phase(model_addr(NB_P - 1), model_len(NB_P - 1), bk, 0, 1'b1);
    sd_rd_done = 1'b1;
    @(negedge clk);
    sd_rd_done = 1'b0;
    vga_vsync = 1'b1;
    vga_bank = nb;
    check_eq("ovl_rise", vga_rise, 1);
    repeat (3) @(negedge clk);
    vga_vsync = 1'b0;
    serve_bursts(0, NB_P - 1, nb, 1, 1);
    end_check(a0, r0, l0, h0, 2, 2 * NB_P, 0, 2 * RH_P);

    // Reset in the middle of a request
    vga_bank = 2'b11;
    pulse_vsync();
    req_phase(0, model_len(0), 2'b11, 0, 1'b0);
    #2;
    rst_133 = 1'b0;
    #1;
    check_eq("arst_req", sd_rd_req, 0);
    check_eq("arst_rise", vga_rise, 0);
    check_eq("arst_aclr", fifo_aclr, 0);
    check_eq("arst_bank", sd_rd_bank, 0);
    repeat (2) @(negedge clk);
    rst_133 = 1'b1;
    a0 = aclr_cnt; r0 = req_rise_cnt;
    repeat (30) @(negedge clk);
    check_eq("post_rst_no_req", req_rise_cnt - r0, 0);
    check_eq("post_rst_no_aclr", aclr_cnt - a0, 0);
    run_frame(2'b10, 1'b0, 2'b00, 1, 5, 0);

    // Randomized frames with a stray done while idle
    for (int f = 0; f < 8; f++) begin
      sd_rd_done = 1'b1;
      @(negedge clk);
      sd_rd_done = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("stray_done_no_req", sd_rd_req, 0);
      run_frame(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                $urandom_range(4, 0), $urandom_range(6, 0), $urandom_range(24, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
